run_detect_fsm: RTL and testbench

//   Parametrised, multi-channel successor to the single-input 'fsm' block.

---
 rtl/run_detect_fsm.sv | 158 +++++++++++++++
 tb/tb_run_detect_fsm.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/run_detect_fsm.sv
// run_detect_fsm: a multi-channel detector for runs of consecutive high samples.
// Each of CHANNELS independent Moore FSMs watches one bit of 'a'.
// - out1[i] is high while channel i's run is at least THRESH samples long.
// - out2[i] pulses for one cycle after a qualifying run ends.
// - run_len holds each channel's current run length and saturates.
// Optional feature: define RUN_DETECT_STATS_EN to add per-channel counters of
// qualified runs. That adds the ports clr_stats and evt_cnt.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         sample enable shared by all channels
//   a          one input bit per channel
//   clr_stats  [stats] clears every evt_cnt
//   evt_cnt    [stats] qualified-run count, ch i at [i*EVT_W +: EVT_W]
//   out1       per-channel HOLD level
//   out2       per-channel one-cycle run-end pulse
//   run_len    per-channel run length, ch i at [i*CNT_W +: CNT_W]
module run_detect_fsm #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned THRESH   = 3,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned EVT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       a,
`ifdef RUN_DETECT_STATS_EN
    input  logic                      clr_stats,
    output logic [CHANNELS*EVT_W-1:0] evt_cnt,
`endif
    output logic [CHANNELS-1:0]       out1,
    output logic [CHANNELS-1:0]       out2,
    output logic [CHANNELS*CNT_W-1:0] run_len
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    localparam logic [CNT_W-1:0] RUN_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Reject parameter sets that the run counter cannot represent.
    if (THRESH < 1 || THRESH > (1 << CNT_W) - 1 || CHANNELS < 1 || EVT_W < 1) begin : g_param_check
        $error("run_detect_fsm: THRESH must be in 1..2^CNT_W-1");
    end

    logic [1:0]       state_q   [CHANNELS];
    logic [1:0]       state_nxt [CHANNELS];
    logic [CNT_W-1:0] run_q     [CHANNELS];
    logic [CNT_W-1:0] run_nxt   [CHANNELS];

    // Next-state and run-length logic, one FSM per channel.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            state_nxt[i] = state_q[i];
            run_nxt[i]   = run_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    run_nxt[i] = '0;
                    if (en && a[i]) begin
                        run_nxt[i]   = ONE;
                        state_nxt[i] = (THR == ONE) ? ST_HOLD : ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (en) begin
                        if (a[i]) begin
                            run_nxt[i] = run_q[i] + ONE;
                            if (run_q[i] + ONE == THR) state_nxt[i] = ST_HOLD;
                        end else begin
                            run_nxt[i]   = '0;
                            state_nxt[i] = ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (en) begin
                        if (a[i]) begin
                            if (run_q[i] != RUN_MAX) run_nxt[i] = run_q[i] + ONE;
                        end else begin
                            state_nxt[i] = ST_END;
                        end
                    end
                end
                ST_END: begin
                    // END always lasts one cycle, so out2 is a single pulse even with en=0.
                    if (en && a[i]) begin
                        run_nxt[i]   = ONE;
                        state_nxt[i] = (THR == ONE) ? ST_HOLD : ST_COUNT;
                    end else begin
                        run_nxt[i]   = '0;
                        state_nxt[i] = ST_IDLE;
                    end
                end
                default: begin
                    run_nxt[i]   = '0;
                    state_nxt[i] = ST_IDLE;
                end
            endcase
        end
    end

    // State, run-length and Moore output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= ST_IDLE;
                run_q[i]   <= '0;
            end
            out1 <= '0;
            out2 <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= state_nxt[i];
                run_q[i]   <= run_nxt[i];
                out1[i]    <= (state_nxt[i] == ST_HOLD);
                out2[i]    <= (state_nxt[i] == ST_END);
            end
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_run_pack
        assign run_len[g*CNT_W +: CNT_W] = run_q[g];
    end

`ifdef RUN_DETECT_STATS_EN
    logic [EVT_W-1:0] evt_q   [CHANNELS];
    logic [EVT_W-1:0] evt_nxt [CHANNELS];

    // Saturating count of END entries; a clear on the same cycle as an END entry leaves 1.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            evt_nxt[i] = evt_q[i];
            if (clr_stats) begin
                evt_nxt[i] = (state_nxt[i] == ST_END) ? EVT_W'(1) : '0;
            end else if (state_nxt[i] == ST_END && evt_q[i] != '1) begin
                evt_nxt[i] = evt_q[i] + EVT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (rst) evt_q[i] <= '0;
            else     evt_q[i] <= evt_nxt[i];
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_evt_pack
        assign evt_cnt[g*EVT_W +: EVT_W] = evt_q[g];
    end
`endif

endmodule

// File: tb/tb_run_detect_fsm.sv
// Testbench for run_detect_fsm: directed scenarios, then random traffic.
// A run-length reference model checks every cycle.
module tb_run_detect_fsm;
    localparam int unsigned CH = 4;
    localparam int unsigned TH = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned EW = 8;
    localparam int RMAX = (1 << CW) - 1;
    localparam int EMAX = (1 << EW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            clr_stats = 1'b0;
    logic [CH-1:0]   a = '0;
    logic [CH-1:0]   out1;
    logic [CH-1:0]   out2;
    logic [CH*CW-1:0] run_len;
`ifdef RUN_DETECT_STATS_EN
    logic [CH*EW-1:0] evt_cnt;
`endif

    always #5 clk = ~clk;

    run_detect_fsm #(.CHANNELS(CH), .THRESH(TH), .CNT_W(CW), .EVT_W(EW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a        (a),
`ifdef RUN_DETECT_STATS_EN
        .clr_stats(clr_stats),
        .evt_cnt  (evt_cnt),
`endif
        .out1     (out1),
        .out2     (out2),
        .run_len  (run_len)
    );

    // Reference model per channel:
    // - run:  consecutive enabled high samples in the current run.
    // - pend: set for the one cycle after a qualifying run ends.
    // - last: length of the run that just ended.
    // - evt:  number of qualified runs.
    int run  [CH];
    bit pend [CH];
    int last [CH];
    int evt  [CH];
    int errors = 0;
    int checks = 0;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic step(input logic r, input logic e, input logic [CH-1:0] av, input logic c);
        logic [CH-1:0]    e1;
        logic [CH-1:0]    e2;
        logic [CH*CW-1:0] erl;
        logic [CH*EW-1:0] eev;
        bit               ended;
        rst = r; en = e; a = av; clr_stats = c;
        @(posedge clk);
        for (int ch = 0; ch < int'(CH); ch++) begin
            if (r) begin
                run[ch] = 0; pend[ch] = 0; last[ch] = 0; evt[ch] = 0;
            end else begin
                ended = 0;
                if (pend[ch]) begin
                    pend[ch] = 0;
                    run[ch]  = (e && av[ch]) ? 1 : 0;
                end else if (e) begin
                    if (av[ch]) run[ch]++;
                    else begin
                        if (run[ch] >= int'(TH)) begin
                            pend[ch] = 1; last[ch] = run[ch]; ended = 1;
                        end
                        run[ch] = 0;
                    end
                end
                if (c) evt[ch] = ended ? 1 : 0;
                else if (ended && evt[ch] < EMAX) evt[ch]++;
            end
            e1[ch] = !pend[ch] && (run[ch] >= int'(TH));
            e2[ch] = pend[ch];
            erl[ch*CW +: CW] = CW'(pend[ch] ? sat(last[ch], RMAX) : sat(run[ch], RMAX));
            eev[ch*EW +: EW] = EW'(evt[ch]);
        end
        #1;
        checks++;
        assert (out1 === e1) else begin
            errors++; $error("FAIL out1 observed=%b expected=%b", out1, e1);
        end
        checks++;
        assert (out2 === e2) else begin
            errors++; $error("FAIL out2 observed=%b expected=%b", out2, e2);
        end
        checks++;
        assert (run_len === erl) else begin
            errors++; $error("FAIL run_len observed=%h expected=%h", run_len, erl);
        end
`ifdef RUN_DETECT_STATS_EN
        checks++;
        assert (evt_cnt === eev) else begin
            errors++; $error("FAIL evt_cnt observed=%h expected=%h", evt_cnt, eev);
        end
`else
        if (eev != eev) errors++;
`endif
    endtask

    logic t1 [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic t4 [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset state.
        step(1'b1, 1'b1, '0, 1'b0);

        // Basic run on ch0.
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, {3'b000, t1[k]}, 1'b0);

        // Short run on ch1.
        step(1'b0, 1'b1, 4'b0010, 1'b0);
        step(1'b0, 1'b1, 4'b0010, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 1'b0);

        // Saturation on ch2.
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 4'b0100, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 1'b0);

        // Back-to-back runs on ch3.
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, {t4[k], 3'b000}, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 1'b0);

        // Enable freeze mid-COUNT, then en=0 during END.
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 4'($urandom), 1'b0);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 4'b1111, 1'b0);
        step(1'b0, 1'b0, 4'b1111, 1'b0);

        // Reset mid-HOLD on every channel.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 1'b0);

        // Three qualified runs on ch1.
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'b0010, 1'b0);
            step(1'b0, 1'b1, 4'b0000, 1'b0);
        end

        // Clear the stats on the same cycle as an END entry on ch1.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'b0010, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 1'b1);
        step(1'b0, 1'b1, 4'b0000, 1'b0);

        // Random traffic, biased toward long high runs.
        for (int k = 0; k < 400; k++) begin
            logic [CH-1:0] av;
            for (int ch = 0; ch < int'(CH); ch++) av[ch] = ($urandom_range(99) < 70);
            step(($urandom_range(99) < 2), ($urandom_range(99) < 85), av,
                 ($urandom_range(99) < 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
